data_mem_stream_loader: RTL and testbench

//  Upstream feeder for the on-chip data memory (Avalon-MM slave, 32-bit, 1-cycle write, no waitrequest).

---
 rtl/data_mem_stream_loader.sv | 137 +++++++++++++
 tb/tb_data_mem_stream_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_stream_loader.sv
// data_mem_stream_loader: packs a byte stream little-endian into 32-bit words written to data memory.
// Optional running byte checksum output when DATA_MEM_LOADER_CHECKSUM_EN is defined.
module data_mem_stream_loader #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 342,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              m_clken
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d, wdata_q, wdata_d;
    logic [3:0]        lane_q, lane_d, be_q, be_d;
    logic              err_q, err_d;
    logic              acc, base_bad, ptr_ovf;
    logic [ADDR_W:0]   ptr_nxt;
    logic [31:0]       word;
    logic [3:0]        lanes;
    assign acc      = s_valid & s_ready;
    assign ptr_nxt  = {1'b0, ptr_q} + 1'b1;
    assign ptr_ovf  = ptr_nxt > LAST;
    assign base_bad = {1'b0, base_addr} > LAST;
    assign word     = buf_q | ({24'b0, s_data} << {idx_q, 3'b000});
    assign lanes    = lane_q | (4'b0001 << idx_q);
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                ptr_d   = base_addr;
                rem_d   = byte_count;
                idx_d   = '0;
                buf_d   = '0;
                lane_d  = '0;
                err_d   = base_bad;
                state_d = (base_bad || byte_count == '0) ? DONE : FILL;
            end
            FILL: if (acc) begin
                rem_d  = rem_q - 1'b1;
                idx_d  = idx_q + 2'd1;
                buf_d  = word;
                lane_d = lanes;
                // Output word registers load only here so they hold steady outside WRITE
                if (idx_q == 2'd3 || rem_q == CNT_W'(1)) begin
                    state_d = WRITE;
                    addr_d  = ptr_q;
                    wdata_d = word;
                    be_d    = lanes;
                end
            end
            WRITE: begin
                ptr_d   = ptr_nxt[ADDR_W-1:0];
                idx_d   = '0;
                buf_d   = '0;
                lane_d  = '0;
                err_d   = rem_q != '0 && ptr_ovf;
                state_d = (rem_q == '0 || ptr_ovf) ? DONE : FILL;
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else if (state_q == IDLE && start) sum_q <= '0;
        else if (acc) sum_q <= sum_q + {24'b0, s_data};
    end
    assign checksum = sum_q;
`endif
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign error        = err_q;
    assign s_ready      = state_q == FILL;
    assign m_write      = state_q == WRITE;
    assign m_chipselect = m_write;
    assign m_address    = addr_q;
    assign m_byteenable = be_q;
    assign m_writedata  = wdata_q;
    assign m_clken      = ~reset;
endmodule

// File: tb/tb_data_mem_stream_loader.sv
// tb_data_mem_stream_loader: scoreboard bench; expected memory writes are queued at stimulus time
// and compared as the loader issues them.
module tb_data_mem_stream_loader;
    localparam int DEPTH = 342;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0;
    logic [8:0]  base_addr = '0;
    logic [10:0] byte_count = '0;
    logic [7:0]  s_data = '0;
    logic        busy, done, error, s_ready, m_chipselect, m_write, m_clken;
    logic [8:0]  m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    typedef struct packed {
        logic [8:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;
    wr_t        exp_q[$];
    wr_t        got;
    logic [7:0] stim[$];
    int         checks = 0, failures = 0;
    int         done_cnt = 0, wr_cnt = 0, rdy_cnt = 0;
    logic       err_at_done = 1'b0;

    data_mem_stream_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .byte_count(byte_count),
        .busy(busy), .done(done), .error(error), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata),
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .m_clken(m_clken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (done) begin
            done_cnt++;
            err_at_done = error;
        end
        if (s_ready) rdy_cnt++;
        if (m_write) begin
            wr_cnt++;
            chk("chipselect", m_chipselect, 1);
            if (exp_q.size() == 0) chk("spurious_write", 1, 0);
            else begin
                got = exp_q.pop_front();
                chk("addr", m_address, got.a);
                chk("data", m_writedata, got.d);
                chk("be", m_byteenable, got.be);
            end
        end
    end

    task automatic run(input logic [8:0] base, input int cnt, input bit gap, input bit poke);
        int nw, avail, n, k, d0, w0, r0, t;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          ee;
        wr_t         w;
        nw    = (cnt + 3) / 4;
        avail = (base > DEPTH - 1) ? 0 : DEPTH - int'(base);
        n     = nw < avail ? nw : avail;
        ee    = (base > DEPTH - 1) || nw > avail;
        wd = '0; be = '0; k = 0;
        for (int i = 0; i < cnt && k < n; i++) begin
            wd |= 32'(stim[i]) << (8 * (i % 4));
            be |= 4'(1 << (i % 4));
            if (i % 4 == 3 || i == cnt - 1) begin
                w.a = base + 9'(k); w.d = wd; w.be = be;
                exp_q.push_back(w);
                k++; wd = '0; be = '0;
            end
        end
        d0 = done_cnt; w0 = wr_cnt; r0 = rdy_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; byte_count = 11'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_on_start", error, base > DEPTH - 1);
        for (int i = 0; i < cnt; i++) begin
            int tt = 0;
            bit a = 1'b0;
            if (done_cnt != d0) break;
            s_data = stim[i]; s_valid = 1'b1;
            if (poke && i == 1) begin start = 1'b1; base_addr = 9'h000; end
            while (!a && tt < 40 && done_cnt == d0) begin
                a = s_ready;
                @(posedge clk); #1;
                start = 1'b0; tt++;
            end
            if (!a && done_cnt == d0) begin chk("stream_timeout", 0, 1); break; end
            s_valid = 1'b0;
            if (gap) begin @(posedge clk); #1; end
        end
        s_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 200) begin @(posedge clk); #1; t++; end
        repeat (8) begin @(posedge clk); #1; end
        chk("done_once", done_cnt - d0, 1);
        chk("nwrites", wr_cnt - w0, n);
        chk("err_at_done", err_at_done, ee);
        chk("err_sticky", error, ee);
        chk("busy_idle", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        if (cnt == 0) chk("no_ready", rdy_cnt - r0, 0);
        exp_q.delete();
    endtask

    task automatic scen1;
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run(9'h010, 8, 1'b0, 1'b0);
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
        chk("checksum", checksum, 32'h0000_0264);
`endif
    endtask

    initial begin
        int d0, w0;
        #1;
        chk("rst_outputs", {busy, done, error, s_ready, m_write, m_chipselect, m_clken,
                            m_address, m_byteenable, m_writedata}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("clken", m_clken, 1);
        scen1();
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run(9'h020, 5, 1'b0, 1'b0);
        stim.delete();
        run(9'h040, 0, 1'b0, 1'b0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run(9'd341, 8, 1'b0, 1'b0);
        stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run(9'd341, 4, 1'b1, 1'b1);
        stim = '{8'h5A, 8'hA5, 8'h3C};
        run(9'h1FF, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 9'h030; byte_count = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'hA1;
        @(posedge clk); #1;
        s_data = 8'hA2;
        @(posedge clk); #1;
        s_valid = 1'b0;
        d0 = done_cnt; w0 = wr_cnt;
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {busy, done, error, s_ready, m_write, m_chipselect, m_clken,
                                m_address, m_byteenable, m_writedata}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", busy, 0);
        scen1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
